// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift operation encodings and the shifter FSM states.
package alu_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One iteration of the sequential shifter: shifts a value by 0..STEP positions
// using the fill rule of the selected operation.
module shift_step
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int STEP   = 1,
  localparam int AW    = $clog2(STEP) + 1
) (
  input  logic [DATA_W-1:0] val_i,
  input  logic [1:0]        op_i,
  input  logic              sign_i,
  input  logic [AW-1:0]     amt_i,
  output logic [DATA_W-1:0] val_o
);

  localparam logic [DATA_W-1:0] ONES = '1;

  logic [DATA_W-1:0] fill_mask;

  always_comb begin
    // Bits vacated by a right shift; the arithmetic shift paints them with the sign.
    fill_mask = ~(ONES >> amt_i);
    case (op_i)
      OP_SLL:  val_o = val_i << amt_i;
      OP_SRL:  val_o = val_i >> amt_i;
      OP_SRA:  val_o = (val_i >> amt_i) | (fill_mask & {DATA_W{sign_i}});
      default: val_o = (val_i >> amt_i) | (val_i << (DATA_W - int'(amt_i)));
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: accepts an operand, shifts it at most STEP bits per
// clock, then holds the result until the consumer takes it.
//
// Handshake: an input transfer happens on a rising edge where i_valid & o_ready;
// an output transfer happens on a rising edge where o_valid & i_ready. o_ready is
// high only in IDLE and o_valid only in DONE, so a hand-off and a new accept never
// share an edge. i_flush outranks both transfers.
module seq_shifter
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SH_W   = 8,
  parameter int STEP   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SH_W-1:0]   i_amt,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic              o_busy,
  output state_t            o_state
);

  localparam int RW = $clog2(DATA_W) + 1;
  localparam int AW = $clog2(STEP) + 1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [1:0]        op_q, op_d;
  logic              sign_q, sign_d;
  logic [RW-1:0]     rem_q, rem_d;

  logic [RW-1:0]     eff_amt;
  logic [AW-1:0]     step_amt;
  logic [RW-1:0]     rem_sub;
  logic [DATA_W-1:0] step_val;

  // Rotates wrap modulo the width; the other ops saturate at a full clear/fill.
  always_comb begin
    if (i_op == OP_ROR) begin
      eff_amt = {1'b0, i_amt[RW-2:0]};
    end else if (i_amt >= SH_W'(DATA_W)) begin
      eff_amt = RW'(DATA_W);
    end else begin
      eff_amt = i_amt[RW-1:0];
    end
  end

  always_comb begin
    if (rem_q > RW'(STEP)) begin
      step_amt = AW'(STEP);
    end else begin
      step_amt = AW'(rem_q);
    end
    rem_sub = rem_q - RW'(step_amt);
  end

  shift_step #(
    .DATA_W (DATA_W),
    .STEP   (STEP)
  ) u_shift_step (
    .val_i  (work_q),
    .op_i   (op_q),
    .sign_i (sign_q),
    .amt_i  (step_amt),
    .val_o  (step_val)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    if (i_flush) begin
      // Abort leaves the working register (and so o_result) untouched.
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            work_d  = i_data;
            op_d    = i_op;
            sign_d  = i_data[DATA_W-1];
            rem_d   = eff_amt;
            state_d = (eff_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work_d = step_val;
          rem_d  = rem_sub;
          if (rem_sub == '0) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      op_q    <= OP_SLL;
      sign_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q == SHIFT);
  assign o_valid  = (state_q == DONE);
  assign o_result = work_q;
  assign o_state  = state_q;

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised multi-cycle shift unit for the ALU datapath.
- Supports logical left, logical right, arithmetic right and rotate right.
- Shifts at most STEP bit positions per clock, so no wide barrel shifter is needed.
- Accepts operands through a valid/ready handshake and holds the result under output valid/ready backpressure.

Parameters:
- DATA_W, 8, operand/result width in bits; power of two, minimum 4.
- SH_W, 8, width of the shift-amount input.
- STEP, 1, maximum bit positions shifted per cycle; power of two, 1 to DATA_W.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  operands valid.
- o_ready  out  1  block can accept operands.
- i_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- i_data  in  DATA_W  operand to shift (two's complement for SRA).
- i_amt  in  SH_W  shift amount, unsigned.
- i_flush  in  1  synchronous abort.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_result  out  DATA_W  shifted result.
- o_busy  out  1  high while in SHIFT.

Behaviour:
- Reset (i_rst_n low, asynchronous): state IDLE; o_ready=1, o_valid=0, o_busy=0, o_result=0; internal remaining count=0.
- States: IDLE, SHIFT, DONE.
- o_ready=1 only in IDLE. o_busy=1 only in SHIFT. o_valid=1 only in DONE.
- Accept: i_valid & o_ready at rising edge t. Latch i_data into the working register; latch i_op; compute effective amount E.
- Effective amount E:
  - SLL, SRL, SRA: E = min(i_amt, DATA_W).
  - ROR: E = i_amt mod DATA_W.
- Transition after accept: E=0 goes to DONE; otherwise goes to SHIFT.
- SHIFT, each cycle:
  - Shift the working register by s = min(STEP, remaining); remaining -= s.
  - Fill: SLL and SRL fill with 0; SRA fills with the original bit DATA_W-1; ROR wraps LSBs into the MSBs.
  - Move to DONE when remaining reaches 0.
- Latency: o_valid rises at t+1+ceil(E/STEP). Examples: E=0 gives t+1; DATA_W=8, STEP=1, E=3 gives t+4.
- o_result is registered and driven from the working register. It is stable while o_valid=1.
- DONE: hold o_result and o_valid until i_valid-independent i_ready=1. Then return to IDLE with o_valid=0 on the next edge.
- No accept in the same cycle as result hand-off. Throughput is one operation per (latency+1) cycles minimum.
- i_flush (sampled each edge, highest priority after reset): next state IDLE, o_valid=0, remaining=0; o_result keeps its last value.
  - i_flush together with an accept: the operation is dropped and the block stays IDLE.
- i_op, i_data and i_amt are ignored outside accept cycles. Changes during SHIFT have no effect.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values; any pending result is lost.
- Boundary results:
  - SRA with i_amt >= DATA_W gives all copies of the sign bit.
  - SLL/SRL with i_amt >= DATA_W gives 0.
  - ROR by any multiple of DATA_W returns i_data unchanged.
- remaining counter width: clog2(DATA_W)+1 bits. No overflow, since E <= DATA_W.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11;
  - state enum: IDLE, SHIFT, DONE.
- One sub-module: shift_step.
  - Combinational; inputs are working value, op, sign bit and amount 0..STEP.
  - Output is the value shifted by that amount under each op's fill rule.
  - Parametrised by DATA_W and STEP; instantiated once.
- Top level holds the FSM, remaining counter, handshake and output register.

Test Plan:
- DATA_W=8, STEP=1, SRA 0x80 by 3, i_ready=1 → o_valid at t+4, o_result=0xF0; o_busy high on cycles t+1..t+3.
- DATA_W=8, STEP=1: SRA 0x80 by 200 → 0xFF at t+9. SRL 0x80 by 200 → 0x00. ROR 0x81 by 9 → 0xC0 at t+2.
- DATA_W=16, STEP=4, SLL 0x0001 by 13 → 0x2000 with o_valid at t+5. Same op with amount 0 → 0x0001 at t+1.
- Backpressure: i_ready=0 for 5 cycles in DONE → o_valid and o_result held. o_ready stays 0 and a second i_valid is not accepted. i_ready=1 → IDLE next edge, then the second op is accepted.
- Flush at the 2nd SHIFT cycle of SRL 0xF0 by 4 → IDLE next edge, o_valid never asserts. Next op SRL 0xF0 by 4 → 0x0F.
- Assert i_rst_n=0 asynchronously mid-SHIFT (between edges) → o_ready=1, o_valid=0, o_busy=0, o_result=0 immediately. Release, then issue SLL 0x03 by 2 → 0x0C.
